serial_add_4bit: RTL and testbench

Bit-serial adder that computes a + b + ci one bit per clock, LSB first, using a single full-adder cell. It is the addition counterpart to the team's 4-bit full subtractor and uses the same operand/carry vocabulary: a, b and ci in, s and co out. It sits as a small arithmetic engine behind a start/done handshake, trading latency for area.

---
 rtl/serial_add_4bit_pkg.sv | 13 +
 rtl/serial_add_4bit_full_add.sv | 13 +
 rtl/serial_add_4bit.sv | 101 ++++++++++
 tb/tb_serial_add_4bit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_4bit_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder.
package serial_add_4bit_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_4bit_full_add.sv
// Single-bit full-adder cell; purely combinational.
module full_add_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s_c,
  output logic o_co_c
);

  assign o_s_c  = i_a ^ i_b ^ i_ci;
  assign o_co_c = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_4bit.sv
// Bit-serial adder: one full-adder cell reused LSB first, start/done handshake,
// registered sum, unsigned carry-out and signed overflow.
module serial_add_4bit
  import serial_add_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_ov
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sum;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic w_s;
  logic w_co;
  logic w_last;
  logic w_accept;

  full_add_1bit u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_ci   (r_c),
    .o_s_c  (w_s),
    .o_co_c (w_co)
  );

  assign w_last   = (r_cnt == LAST);
  assign w_accept = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  // Sum bits enter at the top of r_sum; the final bit completes the word directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_s     <= '0;
      o_co    <= 1'b0;
      o_ov    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          o_done <= 1'b0;
          if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_c     <= i_ci;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_co;
          r_sum <= (WIDTH-1)'({w_s, r_sum} >> 1);
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // r_c here is the carry into the MSB
            o_s     <= {w_s, r_sum};
            o_co    <= w_co;
            o_ov    <= r_c ^ w_co;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_4bit.sv
// Scoreboard bench for serial_add_4bit: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_ci;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_s;
  logic         o_co;
  logic         o_ov;

  serial_add_4bit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_ci    (i_ci),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_s     (o_s),
    .o_co    (o_co),
    .o_ov    (o_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input int acc);
    exp_t       e;
    logic [W:0] t;
    t     = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
    e.s   = t[W-1:0];
    e.co  = t[W];
    e.ov  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    e.acc = acc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (o_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        m_e = q.pop_front();
        chk("sum", int'(o_s), int'(m_e.s));
        chk("carry_out", int'(o_co), int'(m_e.co));
        chk("overflow", int'(o_ov), int'(m_e.ov));
        chk("done_latency", cyc - m_e.acc, W);
        chk("busy_with_done", int'(o_busy), 0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(negedge clk);
    i_a     = a;
    i_b     = b;
    i_ci    = ci;
    i_start = 1'b1;
    q.push_back(model(a, b, ci, cyc + 1));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Returns at the negedge where done is visible; counts busy cycles seen on the way.
  task automatic wait_done(output int busy_n);
    bit got;
    got    = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      if (o_done) got = 1'b1;
      else begin
        if (o_busy) busy_n++;
        @(negedge clk);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_chk(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int bn;
    issue(a, b, ci);
    wait_done(bn);
    chk("busy_cycles", bn, W);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bn;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_ci    = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({o_busy, o_done, o_s, o_co, o_ov}), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_outputs", int'({o_busy, o_done, o_s, o_co, o_ov}), 0);
    end

    run_chk(4'd10, 4'd4, 1'b1);
    run_chk(4'd6,  4'd8, 1'b0);
    run_chk(4'd15, 4'd7, 1'b0);
    run_chk(4'd7,  4'd1, 1'b0);
    run_chk(4'd8,  4'd8, 1'b0);

    // start pulsed during the second RUN cycle must be ignored
    issue(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    i_a     = 4'd1;
    i_b     = 4'd1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(bn);
    repeat (10) @(negedge clk);

    // start during the DONE cycle launches the next run immediately
    issue(4'd5, 4'd5, 1'b0);
    wait_done(bn);
    i_a     = 4'd2;
    i_b     = 4'd1;
    i_ci    = 1'b1;
    i_start = 1'b1;
    q.push_back(model(4'd2, 4'd1, 1'b1, cyc + 1));
    @(negedge clk);
    i_start = 1'b0;
    wait_done(bn);
    chk("busy_cycles_b2b", bn, W);
    @(negedge clk);

    // reset in the third RUN cycle discards the operation
    issue(4'd9, 4'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    chk("mid_reset_busy", int'(o_busy), 0);
    chk("mid_reset_result", int'({o_done, o_s, o_co, o_ov}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run_chk(4'd0, 4'd0, 1'b0);

    // exhaustive back-to-back sweep with start held high
    for (int i = 0; i < 512; i++) begin
      i_a     = 4'(i);
      i_b     = 4'(i >> 4);
      i_ci    = 1'(i >> 8);
      i_start = 1'b1;
      q.push_back(model(4'(i), 4'(i >> 4), 1'(i >> 8), cyc + 1));
      repeat (W + 1) @(negedge clk);
    end
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
